// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and types for the processor-side memory access controller.
package mem_ctrl_pkg;

  localparam int ADDR_W    = 22;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 8193;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_D  = 1'b1;

  // True when a word address lands inside the implemented memory.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pin bundle between the access controller (master) and the word memory (slave).
interface mem_access_ctrl_if;
  import mem_ctrl_pkg::*;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_out;

  modport master (
    output mem_address,
    output mem_in,
    output mem_read,
    output mem_write,
    input  mem_out
  );

  modport slave (
    input  mem_address,
    input  mem_in,
    input  mem_read,
    input  mem_write,
    output mem_out
  );

endinterface

// File: rtl/mem_access_ctrl_arb.sv
// Fixed-priority request selection: the data port always beats instruction fetch.
module mem_req_arb
  import mem_ctrl_pkg::*;
(
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              req_any,
  output logic              grant,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              sel_we,
  output logic [DATA_W-1:0] sel_wdata
);

  // Pick the winning port and present its address, direction and write data.
  always_comb begin
    req_any   = d_req | if_req;
    grant     = d_req ? SRC_D : SRC_IF;
    sel_addr  = d_req ? d_addr : if_addr;
    sel_we    = d_req & d_we;
    sel_wdata = (d_req & d_we) ? d_wdata : '0;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Processor-side initiator for the single-port word memory.
// Optional build macro MEM_BOUNDS_CHECK_EN adds an err output and suppresses
// strobes for addresses beyond the implemented memory.
//
// state  | meaning
// IDLE   | sample requests, register address/data of the winner
// ACCESS | one strobe cycle, read data captured at its closing edge
// RESP   | ack pulse to the winning port, memory pins held stable
module mem_access_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
`ifdef MEM_BOUNDS_CHECK_EN
  output logic              err,
`endif
  mem_access_ctrl_if.master mem
);

  state_t            state;
  logic              src_q;
  logic              we_q;
  logic              req_any;
  logic              grant;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              strobe_ok;
  logic              zero_data;

  mem_req_arb u_arb (
    .if_req    (if_req),
    .if_addr   (if_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .req_any   (req_any),
    .grant     (grant),
    .sel_addr  (sel_addr),
    .sel_we    (sel_we),
    .sel_wdata (sel_wdata)
  );

`ifdef MEM_BOUNDS_CHECK_EN
  logic oob_q;
  assign strobe_ok = addr_in_range(sel_addr);
  assign zero_data = oob_q;
`else
  assign strobe_ok = 1'b1;
  assign zero_data = 1'b0;
`endif

  // Request/strobe/response sequencer; every memory pin and ack is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      src_q           <= SRC_IF;
      we_q            <= 1'b0;
      busy            <= 1'b0;
      if_ack          <= 1'b0;
      d_ack           <= 1'b0;
      if_data         <= '0;
      d_rdata         <= '0;
      mem.mem_address <= '0;
      mem.mem_in      <= '0;
      mem.mem_read    <= 1'b0;
      mem.mem_write   <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      oob_q           <= 1'b0;
      err             <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            state           <= ACCESS;
            busy            <= 1'b1;
            src_q           <= grant;
            we_q            <= sel_we;
            mem.mem_address <= sel_addr;
            mem.mem_in      <= sel_wdata;
            mem.mem_read    <= ~sel_we & strobe_ok;
            mem.mem_write   <= sel_we & strobe_ok;
`ifdef MEM_BOUNDS_CHECK_EN
            oob_q           <= ~strobe_ok;
`endif
          end
        end
        ACCESS: begin
          state         <= RESP;
          mem.mem_read  <= 1'b0;
          mem.mem_write <= 1'b0;
          if (src_q == SRC_D) begin
            d_ack   <= 1'b1;
            d_rdata <= (we_q | zero_data) ? '0 : mem.mem_out;
          end else begin
            if_ack  <= 1'b1;
            if_data <= zero_data ? '0 : mem.mem_out;
          end
`ifdef MEM_BOUNDS_CHECK_EN
          err <= oob_q;
`endif
        end
        RESP: begin
          state  <= IDLE;
          busy   <= 1'b0;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
          err    <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a level-sensitive word memory.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              if_ack, d_ack, busy;
  logic [DATA_W-1:0] if_data, d_rdata;
`ifdef MEM_BOUNDS_CHECK_EN
  logic              err;
`endif

  mem_access_ctrl_if mif ();

  mem_access_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_ack  (if_ack),
    .if_data (if_data),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .busy    (busy),
`ifdef MEM_BOUNDS_CHECK_EN
    .err     (err),
`endif
    .mem     (mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_acks = 0;

  // Preset memory contents, shared by the memory model and the reference.
  function automatic logic [DATA_W-1:0] init_val(input int i);
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'h3F80_0000;
      100:     return 32'h8000_0000;
      101:     return 32'h8040_0001;
      default: return 32'(i) * 32'h9E37_79B1;
    endcase
  endfunction

  // Level-sensitive memory: combinational read, write while mem_write is high.
  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
  assign mif.mem_out = (mif.mem_address < ADDR_W'(MEM_DEPTH)) ?
                       mem[mif.mem_address[13:0]] : 32'hDEAD_BEEF;

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mif.mem_write && mif.mem_address < ADDR_W'(MEM_DEPTH))
        mem[mif.mem_address[13:0]] = mif.mem_in;
    end
  end

  // Bus observers sampled on the falling edge.
  int rd_cycles = 0, wr_cycles = 0, overlap = 0, ack_cnt = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [DATA_W-1:0] last_wr_data = '0;
  always @(negedge clk) begin
    if (mif.mem_read) begin rd_cycles++; last_rd_addr = mif.mem_address; end
    if (mif.mem_write) begin
      wr_cycles++; last_wr_addr = mif.mem_address; last_wr_data = mif.mem_in;
    end
    if (mif.mem_read && mif.mem_write) overlap++;
    if (d_ack) ack_cnt++;
    if (if_ack) ack_cnt++;
  end

  // Reference: what a load/fetch must return, from the last completed stores.
  logic [DATA_W-1:0] ref_mem [0:MEM_DEPTH-1];

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    if (a < ADDR_W'(MEM_DEPTH)) return ref_mem[a[13:0]];
`ifdef MEM_BOUNDS_CHECK_EN
    return '0;
`else
    return 32'hDEAD_BEEF;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_d, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(is_d ? d_ack : if_ack) && n < 8);
  endtask

  // One request (or a fetch/data collision) from an idle controller to idle again.
  task automatic txn(input bit use_if, input bit use_d, input bit we,
                     input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                     input logic [DATA_W-1:0] wd);
    int n;
    logic [DATA_W-1:0] expv;
    if_req = use_if; if_addr = ia;
    d_req = use_d; d_we = we; d_addr = da; d_wdata = wd;
    if (use_d) begin
      expv = we ? '0 : exp_read(da);
      wait_ack(1'b1, n);
      chk("d_latency", n, 2);
      chk("d_rdata", d_rdata, expv);
      chk("if_ack_during_d", if_ack, 0);
`ifdef MEM_BOUNDS_CHECK_EN
      chk("d_err", err, da >= ADDR_W'(MEM_DEPTH));
`endif
      if (we && da < ADDR_W'(MEM_DEPTH)) ref_mem[da[13:0]] = wd;
      exp_acks++;
      d_req = 1'b0;
    end
    if (use_if) begin
      expv = exp_read(ia);
      wait_ack(1'b0, n);
      chk("if_latency", n, use_d ? 3 : 2);
      chk("if_data", if_data, expv);
`ifdef MEM_BOUNDS_CHECK_EN
      chk("if_err", err, ia >= ADDR_W'(MEM_DEPTH));
`endif
      exp_acks++;
      if_req = 1'b0;
    end
    step();
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int r0, w0, kind;
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_val(i);
    reset = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) step();
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mif.mem_read, 0);
    chk("rst_mem_write", mif.mem_write, 0);
    chk("rst_mem_address", mif.mem_address, 0);
    chk("rst_mem_in", mif.mem_in, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_d_rdata", d_rdata, 0);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("rst_err", err, 0);
`endif
    reset = 1'b0;
    step();

    // Fetch with cycle-accurate pin checks.
    if_req = 1; if_addr = 22'd100;
    step();
    chk("fetch_mem_read", mif.mem_read, 1);
    chk("fetch_mem_address", mif.mem_address, 100);
    chk("fetch_busy", busy, 1);
    chk("fetch_early_ack", if_ack, 0);
    step();
    chk("fetch_ack", if_ack, 1);
    chk("fetch_data", if_data, 32'h8000_0000);
    chk("fetch_read_dropped", mif.mem_read, 0);
    exp_acks++;
    if_req = 0;
    step();
    chk("fetch_ack_cleared", if_ack, 0);
    chk("fetch_busy_cleared", busy, 0);

    // Load: no write strobe.
    w0 = wr_cycles;
    txn(0, 1, 0, '0, 22'd1, '0);
    chk("load_value", d_rdata, 32'h3F80_0000);
    chk("load_no_write", wr_cycles - w0, 0);

    // Store then load back.
    w0 = wr_cycles;
    txn(0, 1, 1, '0, 22'd2, 32'h40E0_0000);
    chk("store_write_cycles", wr_cycles - w0, 1);
    chk("store_addr", last_wr_addr, 2);
    chk("store_data", last_wr_data, 32'h40E0_0000);
    txn(0, 1, 0, '0, 22'd2, '0);
    chk("store_readback", d_rdata, 32'h40E0_0000);

    // Collision: data first, fetch three cycles later.
    txn(1, 1, 0, 22'd101, 22'd0, '0);
    chk("collision_if_data", if_data, 32'h8040_0001);

    // Bounds edge and full-width address pass-through.
    r0 = rd_cycles;
    txn(0, 1, 0, '0, 22'd8192, '0);
    chk("addr_8192_read", rd_cycles - r0, 1);
    r0 = rd_cycles;
    txn(0, 1, 0, '0, 22'd8193, '0);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("addr_8193_no_read", rd_cycles - r0, 0);
`else
    chk("addr_8193_read", rd_cycles - r0, 1);
    chk("addr_8193_pass", last_rd_addr, 8193);
    txn(1, 0, 0, 22'h3F_FFFF, '0, '0);
    chk("addr_max_pass", last_rd_addr, 22'h3F_FFFF);
`endif

    // Reset while a store is in ACCESS: strobe dropped, no ack.
    d_req = 1; d_we = 1; d_addr = 22'd5; d_wdata = 32'hCAFE_0005;
    step();
    chk("rst_mid_write_high", mif.mem_write, 1);
    reset = 1;
    step();
    chk("rst_mid_write_low", mif.mem_write, 0);
    chk("rst_mid_no_ack", d_ack, 0);
    chk("rst_mid_busy", busy, 0);
    reset = 0; d_req = 0;
    ref_mem[5] = 32'hCAFE_0005;
    repeat (3) step();

    // Reset on the accepting edge: the store never reaches memory.
    w0 = wr_cycles;
    d_req = 1; d_we = 1; d_addr = 22'd5; d_wdata = 32'hBAD0_0005;
    reset = 1;
    step();
    reset = 0; d_req = 0;
    chk("rst_accept_busy", busy, 0);
    repeat (3) step();
    chk("rst_accept_no_write", wr_cycles - w0, 0);
    chk("rst_accept_mem5", mem[5], ref_mem[5]);

    // Randomized mix of fetches, loads, stores and collisions.
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      txn(kind != 1, kind != 0, 1'($urandom_range(0, 1)),
          22'($urandom_range(0, 63)), 22'($urandom_range(0, 63)), $urandom);
    end

    chk("no_read_write_overlap", overlap, 0);
    chk("ack_count", ack_cnt, exp_acks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
